uart7n_tx_fifo: RTL and testbench

- Transmit-side buffer that sits directly upstream of the uart7n transmitter.
- Accepts bytes from a host over a valid/ready write port and stores them in a FIFO.
- Feeds the transmitter one byte at a time: presents the byte on data_tx_o, drives enable_tx_o, and uses the transmitter's busy/sent status to pop the entry once its frame completes.
- Decouples bursty host writes from the serial bit rate.

---
 rtl/uart7n_tx_fifo.sv | 180 ++++++++++++++++++
 tb/tb_uart7n_tx_fifo.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart7n_tx_fifo.sv
// uart7n_tx_fifo: transmit-side byte FIFO that feeds the uart7n transmitter.
// Host bytes enter over a valid/ready port. A small FSM hands the head byte to
// the transmitter and pops it once the frame has completed.
// Optional feature macro: UART7N_TX_FIFO_FLUSH_EN adds flush_i, which discards
// every queued byte except the one currently in flight.
module uart7n_tx_fifo #(
  parameter int p_depth         = 16,
  parameter int p_start_timeout = 1024
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       wr_valid_i,
  input  logic [7:0]                 wr_data_i,
  output logic                       wr_ready_o,
  output logic [7:0]                 data_tx_o,
  output logic                       enable_tx_o,
  input  logic                       tx_busy_i,
  input  logic                       tx_data_sent_i,
  output logic [$clog2(p_depth):0]   count_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic                       overflow_o,
  output logic                       start_err_o,
  input  logic                       err_clr_i
`ifdef UART7N_TX_FIFO_FLUSH_EN
  ,
  input  logic                       flush_i
`endif
);

  localparam int AW = $clog2(p_depth);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(p_start_timeout + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_t;

  state_t state, next_state;

  logic [7:0]    mem [p_depth];
  logic [CW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [TW-1:0] timer;

  logic full, empty;
  logic push, pop;
  logic load_go, timeout_hit, done_hit;
  logic flush;

  // The extra pointer MSB tells a full buffer apart from an empty one.
  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == CW'(p_depth));
  assign empty   = (count == '0);

`ifdef UART7N_TX_FIFO_FLUSH_EN
  assign flush   = flush_i;
`else
  assign flush   = 1'b0;
`endif

  // A full FIFO rejects writes even if the head pops in the same cycle.
  // A write that arrives together with a flush is discarded.
  assign push        = wr_valid_i & ~full & ~flush;
  assign load_go     = (state == S_IDLE) & ~empty & tx_data_sent_i & ~flush;
  assign timeout_hit = (state == S_WAIT_BUSY) & ~tx_busy_i &
                       (timer == TW'(p_start_timeout - 1));
  assign done_hit    = (state == S_WAIT_DONE) & ~tx_busy_i & tx_data_sent_i;
  assign pop         = timeout_hit | done_hit;

  assign wr_ready_o  = ~full;
  assign full_o      = full;
  assign empty_o     = empty;
  assign count_o     = count;

  // Storage array, written at the tail; no reset is needed on the data.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= wr_data_i;
    end
  end

  // Pointer update; a flush keeps only the in-flight entry, unless it pops now.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      rd_ptr <= rd_ptr + CW'(pop);
`ifdef UART7N_TX_FIFO_FLUSH_EN
      if (flush_i) begin
        wr_ptr <= rd_ptr + CW'((state != S_IDLE) & ~pop);
      end else begin
        wr_ptr <= wr_ptr + CW'(push);
      end
`else
      wr_ptr <= wr_ptr + CW'(push);
`endif
    end
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic for the transmitter handshake.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:      if (load_go) next_state = S_LOAD;
      S_LOAD:      next_state = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (tx_busy_i) begin
          next_state = S_WAIT_DONE;
        end else if (timeout_hit) begin
          next_state = S_IDLE;
        end
      end
      S_WAIT_DONE: if (done_hit) next_state = S_IDLE;
      default:     next_state = S_IDLE;
    endcase
  end

  // Enable is held for the whole life of a frame and dropped only in IDLE.
  always_comb begin
    enable_tx_o = 1'b0;
    case (state)
      S_LOAD, S_WAIT_BUSY, S_WAIT_DONE: enable_tx_o = 1'b1;
      default:                          enable_tx_o = 1'b0;
    endcase
  end

  // The byte is captured only when leaving IDLE, so it never moves mid-frame.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_tx_o <= 8'h00;
    end else if (load_go) begin
      data_tx_o <= mem[rd_ptr[AW-1:0]];
    end
  end

  // Start timeout counter; it runs only while waiting for busy to rise.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      timer <= '0;
    end else if ((state == S_WAIT_BUSY) && !tx_busy_i && !timeout_hit) begin
      timer <= timer + 1'b1;
    end else begin
      timer <= '0;
    end
  end

  // Sticky error flags; a new error event beats a clear in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      overflow_o  <= 1'b0;
      start_err_o <= 1'b0;
    end else begin
      if (wr_valid_i && full) begin
        overflow_o <= 1'b1;
      end else if (err_clr_i) begin
        overflow_o <= 1'b0;
      end
      if (timeout_hit) begin
        start_err_o <= 1'b1;
      end else if (err_clr_i) begin
        start_err_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart7n_tx_fifo.sv
// tb_uart7n_tx_fifo: directed self-checking bench for uart7n_tx_fifo.
// The FIFO is built with 4 entries and the default 1024-cycle start timeout.
// When UART7N_TX_FIFO_FLUSH_EN is defined, the flush scenario is also run.
module tb_uart7n_tx_fifo;

  localparam int DEPTH = 4;
  localparam int TMO   = 1024;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       wr_valid_i = 1'b0;
  logic [7:0] wr_data_i = 8'h00;
  logic       wr_ready_o;
  logic [7:0] data_tx_o;
  logic       enable_tx_o;
  logic       tx_busy_i = 1'b0;
  logic       tx_data_sent_i = 1'b1;
  logic [2:0] count_o;
  logic       empty_o;
  logic       full_o;
  logic       overflow_o;
  logic       start_err_o;
  logic       err_clr_i = 1'b0;
`ifdef UART7N_TX_FIFO_FLUSH_EN
  logic       flush_i = 1'b0;
`endif

  int assertCount = 0;
  int failCount   = 0;

  uart7n_tx_fifo #(
    .p_depth         (DEPTH),
    .p_start_timeout (TMO)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .wr_valid_i     (wr_valid_i),
    .wr_data_i      (wr_data_i),
    .wr_ready_o     (wr_ready_o),
    .data_tx_o      (data_tx_o),
    .enable_tx_o    (enable_tx_o),
    .tx_busy_i      (tx_busy_i),
    .tx_data_sent_i (tx_data_sent_i),
    .count_o        (count_o),
    .empty_o        (empty_o),
    .full_o         (full_o),
    .overflow_o     (overflow_o),
    .start_err_o    (start_err_o),
    .err_clr_i      (err_clr_i)
`ifdef UART7N_TX_FIFO_FLUSH_EN
    ,
    .flush_i        (flush_i)
`endif
  );

  // 100 MHz clock.
  always #5 clk_i = ~clk_i;

  // Hard time limit so the run always ends.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: time limit reached, got running, expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one active edge and land 1 ns after it, where outputs are sampled
  // and new inputs are driven.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Present one byte for a single edge.
  task automatic applyStimulus(input logic [7:0] b);
    wr_valid_i = 1'b1;
    wr_data_i  = b;
    step();
    wr_valid_i = 1'b0;
  endtask

  // Transmitter model for one frame: wait for enable, check the byte, go busy
  // for a few cycles while checking data stays put, then finish the frame.
  task automatic runFrame(input string tag, input logic [7:0] expected);
    for (int i = 0; i < 20 && !enable_tx_o; i++) step();
    checkOutput({tag, "_en"}, enable_tx_o, 1);
    checkOutput({tag, "_data"}, data_tx_o, expected);
    tx_busy_i      = 1'b1;
    tx_data_sent_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checkOutput({tag, "_stable"}, data_tx_o, expected);
    end
    tx_busy_i      = 1'b0;
    tx_data_sent_i = 1'b1;
    step();
    checkOutput({tag, "_drop"}, enable_tx_o, 0);
  endtask

  initial begin
    int cycles;
    $display("[TB] start");

    // Reset values.
    rst_i = 1'b1;
    step();
    step();
    checkOutput("rst_data", data_tx_o, 8'h00);
    checkOutput("rst_en", enable_tx_o, 0);
    checkOutput("rst_ready", wr_ready_o, 1);
    checkOutput("rst_empty", empty_o, 1);
    checkOutput("rst_full", full_o, 0);
    checkOutput("rst_ovf", overflow_o, 0);
    checkOutput("rst_serr", start_err_o, 0);
    checkOutput("rst_count", count_o, 0);
    rst_i = 1'b0;
    step();

    // Single byte, idle transmitter: enable rises at the second edge
    // counting the write edge.
    applyStimulus(8'h55);
    checkOutput("lat_count", count_o, 1);
    checkOutput("lat_en_early", enable_tx_o, 0);
    step();
    checkOutput("lat_en", enable_tx_o, 1);
    checkOutput("lat_data", data_tx_o, 8'h55);
    tx_busy_i      = 1'b1;
    tx_data_sent_i = 1'b0;
    step();
    step();
    step();
    checkOutput("lat_inflight_count", count_o, 1);
    tx_busy_i      = 1'b0;
    tx_data_sent_i = 1'b1;
    step();
    checkOutput("lat_done_count", count_o, 0);
    checkOutput("lat_done_empty", empty_o, 1);

    // Three back-to-back writes come out in order.
    applyStimulus(8'h41);
    applyStimulus(8'h42);
    applyStimulus(8'h43);
    runFrame("seq41", 8'h41);
    runFrame("seq42", 8'h42);
    runFrame("seq43", 8'h43);
    checkOutput("seq_empty", empty_o, 1);

    // Fill with the transmitter held not-sent, then overflow.
    tx_data_sent_i = 1'b0;
    applyStimulus(8'hA0);
    applyStimulus(8'hA1);
    applyStimulus(8'hA2);
    checkOutput("fill3_full", full_o, 0);
    applyStimulus(8'hA3);
    checkOutput("fill_full", full_o, 1);
    checkOutput("fill_ready", wr_ready_o, 0);
    checkOutput("fill_count", count_o, 4);
    checkOutput("fill_ovf_pre", overflow_o, 0);
    applyStimulus(8'hA4);
    checkOutput("ovf_set", overflow_o, 1);
    checkOutput("ovf_count", count_o, 4);
    wr_valid_i = 1'b1;
    wr_data_i  = 8'hA5;
    err_clr_i  = 1'b1;
    step();
    checkOutput("ovf_set_wins", overflow_o, 1);
    wr_valid_i = 1'b0;
    step();
    checkOutput("ovf_clear", overflow_o, 0);
    err_clr_i = 1'b0;
    tx_data_sent_i = 1'b1;
    runFrame("drainA0", 8'hA0);
    runFrame("drainA1", 8'hA1);
    runFrame("drainA2", 8'hA2);
    runFrame("drainA3", 8'hA3);
    checkOutput("drain_empty", empty_o, 1);
    step();
    checkOutput("drain_idle", enable_tx_o, 0);

    // Transmitter never goes busy: start error after the timeout, byte dropped.
    applyStimulus(8'h66);
    applyStimulus(8'h77);
    checkOutput("tmo_en", enable_tx_o, 1);
    checkOutput("tmo_data", data_tx_o, 8'h66);
    cycles = 0;
    while (!start_err_o && cycles < TMO + 100) begin
      step();
      cycles++;
    end
    checkOutput("tmo_cycles", cycles, TMO + 1);
    checkOutput("tmo_serr", start_err_o, 1);
    checkOutput("tmo_count", count_o, 1);
    checkOutput("tmo_en_drop", enable_tx_o, 0);
    runFrame("tmo_next77", 8'h77);
    checkOutput("tmo_serr_sticky", start_err_o, 1);
    err_clr_i = 1'b1;
    step();
    err_clr_i = 1'b0;
    checkOutput("tmo_serr_clear", start_err_o, 0);

    // Enqueue and pop in the same cycle with two entries stored.
    tx_data_sent_i = 1'b0;
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    checkOutput("sim_count_pre", count_o, 2);
    tx_data_sent_i = 1'b1;
    step();
    checkOutput("sim_data11", data_tx_o, 8'h11);
    tx_busy_i      = 1'b1;
    tx_data_sent_i = 1'b0;
    step();
    step();
    tx_busy_i      = 1'b0;
    tx_data_sent_i = 1'b1;
    wr_valid_i     = 1'b1;
    wr_data_i      = 8'h33;
    step();
    wr_valid_i = 1'b0;
    checkOutput("sim_count", count_o, 2);
    step();
    checkOutput("sim_data22", data_tx_o, 8'h22);
    tx_busy_i      = 1'b1;
    tx_data_sent_i = 1'b0;
    step();
    step();
    checkOutput("sim_waitdone_en", enable_tx_o, 1);

    // Reset while the frame is in flight.
    rst_i = 1'b1;
    step();
    checkOutput("mrst_en", enable_tx_o, 0);
    checkOutput("mrst_data", data_tx_o, 8'h00);
    checkOutput("mrst_count", count_o, 0);
    checkOutput("mrst_empty", empty_o, 1);
    checkOutput("mrst_ready", wr_ready_o, 1);
    checkOutput("mrst_full", full_o, 0);
    checkOutput("mrst_ovf", overflow_o, 0);
    checkOutput("mrst_serr", start_err_o, 0);
    rst_i          = 1'b0;
    tx_busy_i      = 1'b0;
    tx_data_sent_i = 1'b1;
    step();
    checkOutput("mrst_stay_idle", enable_tx_o, 0);

`ifdef UART7N_TX_FIFO_FLUSH_EN
    // Flush keeps only the in-flight byte, which still completes.
    applyStimulus(8'h81);
    applyStimulus(8'h82);
    applyStimulus(8'h83);
    tx_busy_i      = 1'b1;
    tx_data_sent_i = 1'b0;
    step();
    checkOutput("fl_count_pre", count_o, 3);
    checkOutput("fl_data", data_tx_o, 8'h81);
    flush_i    = 1'b1;
    wr_valid_i = 1'b1;
    wr_data_i  = 8'h84;
    step();
    flush_i    = 1'b0;
    wr_valid_i = 1'b0;
    checkOutput("fl_count", count_o, 1);
    checkOutput("fl_en", enable_tx_o, 1);
    tx_busy_i      = 1'b0;
    tx_data_sent_i = 1'b1;
    step();
    checkOutput("fl_empty", empty_o, 1);
    step();
    checkOutput("fl_idle", enable_tx_o, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
